// File: rtl/mul_issue_arbiter.sv
// mul_issue_arbiter: issues requests from two requesters into one pipelined multiplier and steers each result back
//
// Ports:
//   clk, rst              clock; asynchronous active-low reset
//   arb_en                1 = grants allowed, 0 = no new grants (in-flight ops still drain)
//   reqN_valid/ready      request handshake for requester N (N = 0, 1); ready marks the granted requester
//   reqN_opa/opb          32-bit operands for requester N
//   reqN_opcode/precision 2-bit opcode and precision for requester N
//   operand_a_reg, operand_b_reg, opcode_reg, precision_reg
//                         registered multiplier inputs, loaded on each handshake
//   mul_out               multiplier result, valid MUL_LATENCY cycles after its inputs are driven
//   rspN_valid            one-cycle strobe: rsp_data holds requester N's result
//   rsp_data              combinational copy of mul_out
//   busy                  an operation is in flight or is being granted this cycle
//
// Build option: define MUL_ARB_FIXED_PRIO_EN to give requester 0 fixed priority
// instead of round-robin arbitration.
module mul_issue_arbiter #(
    parameter int MUL_LATENCY = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        arb_en,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_opa,
    input  logic [31:0] req0_opb,
    input  logic [1:0]  req0_opcode,
    input  logic [1:0]  req0_precision,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_opa,
    input  logic [31:0] req1_opb,
    input  logic [1:0]  req1_opcode,
    input  logic [1:0]  req1_precision,
    output logic [31:0] operand_a_reg,
    output logic [31:0] operand_b_reg,
    output logic [1:0]  opcode_reg,
    output logic [1:0]  precision_reg,
    input  logic [31:0] mul_out,
    output logic        rsp0_valid,
    output logic        rsp1_valid,
    output logic [31:0] rsp_data,
    output logic        busy
);
    logic                 gnt0, gnt1, hs;
    logic [31:0]          opa_d, opa_q, opb_d, opb_q;
    logic [1:0]           opc_d, opc_q, prec_d, prec_q;
    logic [MUL_LATENCY:0] tv_d, tv_q, tid_d, tid_q;

    // Grants are suppressed while reset is asserted so every output reads 0 during reset.
`ifdef MUL_ARB_FIXED_PRIO_EN
    assign gnt0 = arb_en & rst & req0_valid;
    assign gnt1 = arb_en & rst & req1_valid & ~req0_valid;
`else
    logic last_d, last_q;
    // On contention the requester that did not win last time gets the grant.
    assign gnt0   = arb_en & rst & req0_valid & (~req1_valid | last_q);
    assign gnt1   = arb_en & rst & req1_valid & (~req0_valid | ~last_q);
    assign last_d = hs ? gnt1 : last_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) last_q <= 1'b1;
        else      last_q <= last_d;
    end
`endif

    assign hs = gnt0 | gnt1;

    always_comb begin
        opa_d  = hs ? (gnt1 ? req1_opa       : req0_opa)       : opa_q;
        opb_d  = hs ? (gnt1 ? req1_opb       : req0_opb)       : opb_q;
        opc_d  = hs ? (gnt1 ? req1_opcode    : req0_opcode)    : opc_q;
        prec_d = hs ? (gnt1 ? req1_precision : req0_precision) : prec_q;
        // Stage 0 captures this cycle's issue; the last stage lines up with mul_out.
        tv_d   = {tv_q[MUL_LATENCY-1:0], hs};
        tid_d  = {tid_q[MUL_LATENCY-1:0], gnt1};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            opa_q  <= '0;
            opb_q  <= '0;
            opc_q  <= '0;
            prec_q <= '0;
            tv_q   <= '0;
            tid_q  <= '0;
        end else begin
            opa_q  <= opa_d;
            opb_q  <= opb_d;
            opc_q  <= opc_d;
            prec_q <= prec_d;
            tv_q   <= tv_d;
            tid_q  <= tid_d;
        end
    end

    assign req0_ready    = gnt0;
    assign req1_ready    = gnt1;
    assign operand_a_reg = opa_q;
    assign operand_b_reg = opb_q;
    assign opcode_reg    = opc_q;
    assign precision_reg = prec_q;
    assign rsp0_valid    = tv_q[MUL_LATENCY] & ~tid_q[MUL_LATENCY];
    assign rsp1_valid    = tv_q[MUL_LATENCY] & tid_q[MUL_LATENCY];
    assign rsp_data      = mul_out;
    assign busy          = (|tv_q) | hs;
endmodule

// File: tb/tb_mul_issue_arbiter.sv
// tb_mul_issue_arbiter: randomized self-checking bench for mul_issue_arbiter against a scoreboard model
module tb_mul_issue_arbiter;
    localparam int L = 3;

    typedef struct {
        int          due;
        logic        id;
        logic [31:0] prod;
    } rsp_t;
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
    } op_t;

    logic        clk, rst, arb_en;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_opa, req0_opb, req1_opa, req1_opb;
    logic [1:0]  req0_opcode, req0_precision, req1_opcode, req1_precision;
    logic [31:0] operand_a_reg, operand_b_reg, mul_out, rsp_data;
    logic [1:0]  opcode_reg, precision_reg;
    logic        rsp0_valid, rsp1_valid, busy;
    logic [31:0] mpipe [L];

    rsp_t        mq[$];
    op_t         q0[$], q1[$];
    logic        m_last, hs0, hs1, gap;
    logic [36:0] obs, expv;
    int          cyc, nvec, nfail;

    mul_issue_arbiter #(.MUL_LATENCY(L)) dut (
        .clk(clk), .rst(rst), .arb_en(arb_en),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opa(req0_opa), .req0_opb(req0_opb),
        .req0_opcode(req0_opcode), .req0_precision(req0_precision),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opa(req1_opa), .req1_opb(req1_opb),
        .req1_opcode(req1_opcode), .req1_precision(req1_precision),
        .operand_a_reg(operand_a_reg), .operand_b_reg(operand_b_reg),
        .opcode_reg(opcode_reg), .precision_reg(precision_reg),
        .mul_out(mul_out), .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
        .rsp_data(rsp_data), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier stand-in: product of the registered operands, L cycles later.
    always @(posedge clk) begin
        mpipe[0] <= operand_a_reg * operand_b_reg;
        for (int i = 1; i < L; i++) mpipe[i] <= mpipe[i-1];
    end
    assign mul_out = mpipe[L-1];

    // One cycle: sample DUT at the falling edge, form expectations from the scoreboard, advance.
    task automatic step();
        logic g0, g1, e0, e1;
        logic [31:0] ed, p;
        @(negedge clk);
        obs = {req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy, 32'h0};
        g0 = 1'b0;
        g1 = 1'b0;
        if (!rst) begin
            mq.delete();
            m_last = 1'b1;
            expv = '0;
        end else begin
`ifdef MUL_ARB_FIXED_PRIO_EN
            g0 = arb_en && req0_valid;
            g1 = arb_en && req1_valid && !req0_valid;
`else
            if (arb_en && req0_valid && req1_valid) begin
                g0 = (m_last == 1'b1);
                g1 = !g0;
            end else begin
                g0 = arb_en && req0_valid;
                g1 = arb_en && req1_valid;
            end
`endif
            e0 = 1'b0;
            e1 = 1'b0;
            ed = '0;
            if (mq.size() != 0 && mq[0].due == cyc) begin
                e0 = !mq[0].id;
                e1 = mq[0].id;
                ed = mq[0].prod;
                mq.delete(0);
            end
            expv = {g0, g1, e0, e1, (mq.size() != 0) || e0 || e1 || g0 || g1, ed};
            if (e0 || e1) obs[31:0] = rsp_data;
            if (g0 || g1) begin
                p = g1 ? req1_opa * req1_opb : req0_opa * req0_opb;
                mq.push_back('{due: cyc + 1 + L, id: g1, prod: p});
                m_last = g1;
            end
        end
        hs0 = g0;
        hs1 = g1;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Requesters: present the head of their op queue, hold it until the handshake.
    task automatic present();
        if (hs0) begin q0.delete(0); req0_valid = 1'b0; end
        if (hs1) begin q1.delete(0); req1_valid = 1'b0; end
        if (!req0_valid && q0.size() != 0 && (!gap || $urandom_range(0, 1) == 1)) begin
            req0_valid = 1'b1;
            req0_opa = q0[0].a;
            req0_opb = q0[0].b;
            req0_opcode = 2'($urandom);
            req0_precision = 2'($urandom);
        end
        if (!req1_valid && q1.size() != 0 && (!gap || $urandom_range(0, 1) == 1)) begin
            req1_valid = 1'b1;
            req1_opa = q1[0].a;
            req1_opb = q1[0].b;
            req1_opcode = 2'($urandom);
            req1_precision = 2'($urandom);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        arb_en = 1'b1;
        req0_valid = 1'b1;
        repeat (3) begin
            step();
            nvec++;
            if (obs !== expv) begin nfail++; $display("FAIL reset cyc=%0d got=%h want=%h", cyc, obs, expv); end
            nvec++;
            if ({operand_a_reg, operand_b_reg, opcode_reg, precision_reg} !== 68'h0) begin
                nfail++;
                $display("FAIL reset_regs got=%h/%h/%h/%h want=0", operand_a_reg, operand_b_reg, opcode_reg, precision_reg);
            end
        end
        req0_valid = 1'b0;
        rst = 1'b1;
    endtask

    task automatic test_single();
        q0.push_back('{a: 32'd5, b: 32'd7});
        present();
        repeat (8) begin
            step();
            nvec++;
            if (obs !== expv) begin nfail++; $display("FAIL single cyc=%0d got=%h want=%h", cyc, obs, expv); end
            present();
        end
    endtask

    task automatic test_contention();
        for (int k = 0; k < 3; k++) begin
            q0.push_back('{a: 32'd100 + k, b: 32'd11});
            q1.push_back('{a: 32'd200 + k, b: 32'd13});
        end
        present();
        repeat (12) begin
            step();
            nvec++;
            if (obs !== expv) begin nfail++; $display("FAIL contention cyc=%0d got=%h want=%h", cyc, obs, expv); end
            present();
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 1; k <= 5; k++) q1.push_back('{a: k, b: 32'd3});
        present();
        repeat (11) begin
            step();
            nvec++;
            if (obs !== expv) begin nfail++; $display("FAIL back_to_back cyc=%0d got=%h want=%h", cyc, obs, expv); end
            present();
        end
    endtask

    task automatic test_arb_en();
        arb_en = 1'b0;
        q0.push_back('{a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF});
        present();
        repeat (3) begin
            step();
            nvec++;
            if (obs !== expv) begin nfail++; $display("FAIL arb_en_off cyc=%0d got=%h want=%h", cyc, obs, expv); end
            present();
        end
        arb_en = 1'b1;
        repeat (6) begin
            step();
            nvec++;
            if (obs !== expv) begin nfail++; $display("FAIL arb_en_on cyc=%0d got=%h want=%h", cyc, obs, expv); end
            present();
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 3; k++) q0.push_back('{a: 32'd9 + k, b: 32'd4});
        present();
        repeat (5) begin
            step();
            nvec++;
            if (obs !== expv) begin nfail++; $display("FAIL pre_reset cyc=%0d got=%h want=%h", cyc, obs, expv); end
            present();
        end
        rst = 1'b0;
        repeat (2) begin
            step();
            nvec++;
            if (obs !== expv) begin nfail++; $display("FAIL mid_reset cyc=%0d got=%h want=%h", cyc, obs, expv); end
            nvec++;
            if ({operand_a_reg, operand_b_reg, opcode_reg, precision_reg} !== 68'h0) begin
                nfail++;
                $display("FAIL mid_reset_regs got=%h/%h/%h/%h want=0", operand_a_reg, operand_b_reg, opcode_reg, precision_reg);
            end
            present();
        end
        rst = 1'b1;
        q1.push_back('{a: 32'd6, b: 32'd6});
        present();
        repeat (8) begin
            step();
            nvec++;
            if (obs !== expv) begin nfail++; $display("FAIL post_reset cyc=%0d got=%h want=%h", cyc, obs, expv); end
            present();
        end
    endtask

    task automatic test_random();
        gap = 1'b1;
        repeat (400) begin
            if ($urandom_range(0, 2) == 0) q0.push_back('{a: $urandom, b: $urandom});
            if ($urandom_range(0, 2) == 0) q1.push_back('{a: $urandom, b: $urandom});
            arb_en = ($urandom_range(0, 7) != 0);
            present();
            step();
            nvec++;
            if (obs !== expv) begin nfail++; $display("FAIL random cyc=%0d got=%h want=%h", cyc, obs, expv); end
        end
        arb_en = 1'b1;
        gap = 1'b0;
        present();
        for (int k = 0; k < 200 && (q0.size() != 0 || q1.size() != 0 || mq.size() != 0); k++) begin
            step();
            nvec++;
            if (obs !== expv) begin nfail++; $display("FAIL drain cyc=%0d got=%h want=%h", cyc, obs, expv); end
            present();
        end
        nvec++;
        if (mq.size() != 0 || busy !== 1'b0) begin
            nfail++;
            $display("FAIL drain_idle busy=%b pending=%0d want busy=0 pending=0", busy, mq.size());
        end
    endtask

    initial begin
        cyc = 0; nvec = 0; nfail = 0;
        m_last = 1'b1; hs0 = 1'b0; hs1 = 1'b0; gap = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_opa = '0; req0_opb = '0; req0_opcode = '0; req0_precision = '0;
        req1_opa = '0; req1_opb = '0; req1_opcode = '0; req1_precision = '0;
        test_reset();
        test_single();
        test_contention();
        test_back_to_back();
        test_arb_en();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule

// File: doc/mul_issue_arbiter.md
Name: mul_issue_arbiter

Overview:
- Shares one precision-controlled 32-bit vector multiplier between two requesters.
- Round-robin arbitration with valid/ready handshakes on the request side; issues at most one operation per cycle into the multiplier's registered inputs.
- Tracks in-flight operations with a tag pipeline and returns each result to the requester that issued it.
- Sits directly in front of the multiplier wrapper and drives its operand_a_reg/operand_b_reg/opcode_reg/precision_reg inputs.

Parameters:
- MUL_LATENCY, 3: cycles from the multiplier input registers being driven to the matching mul_out being valid. Legal range 1..8.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-low reset
- arb_en  input  1  1 = grants allowed; 0 = no new grants, in-flight operations drain
- req0_valid  input  1  requester 0 has an operation
- req0_ready  output  1  requester 0 granted this cycle
- req0_opa  input  32  requester 0 operand A
- req0_opb  input  32  requester 0 operand B
- req0_opcode  input  2  requester 0 opcode
- req0_precision  input  2  requester 0 precision
- req1_valid, req1_ready, req1_opa, req1_opb, req1_opcode, req1_precision: same as requester 0, for requester 1
- operand_a_reg  output  32  to multiplier
- operand_b_reg  output  32  to multiplier
- opcode_reg  output  2  to multiplier
- precision_reg  output  2  to multiplier
- mul_out  input  32  multiplier result
- rsp0_valid  output  1  result for requester 0 on rsp_data
- rsp1_valid  output  1  result for requester 1 on rsp_data
- rsp_data  output  32  equals mul_out (combinational pass-through)
- busy  output  1  any operation in flight or granted this cycle

Behaviour:
- Interface: single clock clk; reset rst is asynchronous, active-low.
- Reset values:
  - operand_a_reg, operand_b_reg, opcode_reg, precision_reg = 0.
  - Tag pipeline cleared.
  - last_grant = 1, so requester 0 wins the first contention.
  - rsp0_valid = rsp1_valid = 0; busy = 0.
- Arbitration (combinational), when arb_en = 1:
  - Only one valid: grant it.
  - Both valid: grant the requester not equal to last_grant.
  - When arb_en = 0: no grant.
  - reqN_ready is high only in the granted requester's cycle. Ready may depend on valid; a requester's valid must not depend on ready.
  - Handshake is valid & ready. A requester holds its valid and payload stable until the handshake.
- Issue, on each handshake cycle N:
  - Granted payload is registered into the multiplier outputs at the end of cycle N.
  - last_grant is updated to the granted index.
  - No handshake: the multiplier outputs hold their last values, and no tag is inserted.
- Tag pipeline:
  - Shift register of MUL_LATENCY+1 entries, each {valid, id}, advancing every cycle.
  - Stage 0 is loaded at the end of cycle N with {handshake, granted id}.
  - Final stage drives rspN_valid = tag.valid & (tag.id == N).
  - Response for a handshake in cycle N is asserted in cycle N+1+MUL_LATENCY, exactly one cycle wide.
- Responses:
  - No backpressure; the requester must accept rspN_valid when it is asserted.
  - Results return in issue order.
  - Back-to-back issues produce back-to-back responses.
- Throughput: 1 operation per cycle; fully pipelined, no outstanding limit.
- Idle requester: if the winning requester drops valid, the other requester is granted the same cycle.
- busy = OR of all tag valid bits OR any handshake this cycle.
- arb_en deasserted mid-stream: in-flight responses still complete on schedule; busy falls after the last one.
- Reset mid-operation: all tags are dropped and no stale responses appear. Multiplier outputs return to 0.

Optional Feature:
- Macro: MUL_ARB_FIXED_PRIO_EN.
- Defined: requester 0 always wins contention; last_grant is not used for arbitration. Requester 1 is granted only when req0_valid = 0.
- Undefined: round-robin as described above.

Test Plan:
- Single issue: reset, MUL_LATENCY = 3, multiplier model returns (a*b)[31:0]; req0 opa = 5, opb = 7 handshake in cycle 10 -> rsp0_valid high only in cycle 14 with rsp_data = 35; rsp1_valid never high; busy high cycles 10..14.
- Contention: both valid continuously for 6 cycles with distinct operands -> grants alternate 0,1,0,1,0,1. Responses follow in the same order 4 cycles later, each with the matching product.
- Back-to-back single requester: req1 valid for 5 cycles with opa = 1..5, opb = 3 -> five consecutive rsp1_valid cycles with data 3,6,9,12,15.
- arb_en gating: arb_en = 0 with req0_valid = 1 -> req0_ready stays 0 and busy = 0. Set arb_en = 1 -> grant the same cycle.
- Reset mid-flight: issue 3 ops, assert rst 2 cycles later -> no rspN_valid ever appears for them; all outputs = 0 during reset. After release, a new op completes normally.
- MUL_ARB_FIXED_PRIO_EN defined, both requesters valid for 4 cycles -> req0 granted all 4 cycles, req1_ready = 0 throughout; req1 granted in the first cycle req0_valid = 0.
